// File: rtl/serial_adder_if.sv
// ============================================================================
// Module      : serial_adder_if
// Description : Bundles the operation request and result signals of the
//               bit-serial adder/subtractor.
//   start    - request to begin an operation (taken in IDLE only)
//   sub      - 0 = a+b, 1 = a-b, captured together with an accepted start
//   a, b     - serial operand bits, LSB first
//   s        - registered serial result bit
//   s_valid  - s carries a valid result bit
//   c        - carry-out (add) / not-borrow (subtract) of the last operation
//   sum      - parallel result of the last operation
//   busy     - operation in progress (RUN or DONE)
//   done     - one-cycle completion pulse
//   master   - requester side; slave - adder side
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             a;
  logic             b;
  logic             s;
  logic             s_valid;
  logic             c;
  logic [WIDTH-1:0] sum;
  logic             busy;
  logic             done;

  modport master (
    output start, sub, a, b,
    input  s, s_valid, c, sum, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output s, s_valid, c, sum, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder/subtractor. Operands arrive LSB first, one
//               bit per clock; bit 0 is taken on the same edge that accepts
//               start. Each bit is one full-adder step; subtraction uses
//               a + ~b + 1.
//   clk    - rising-edge clock
//   reset  - asynchronous active-high reset
//   bus    - serial_adder_if.slave (start, sub, a, b -> s, s_valid, c,
//            sum, busy, done)
//   WIDTH  - operand width, 1..32
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;

  logic [CW-1:0]    cnt;       // position of the most recently sampled bit
  logic [CW-1:0]    pos;       // position being sampled this cycle
  logic             accept;
  logic             sample;
  logic             last;

  logic             sub_l;
  logic             carry;
  logic             s_r;
  logic             s_valid_r;
  logic             c_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_n;

  logic             sub_eff;
  logic             b_eff;
  logic             cin;
  logic             fs;
  logic             co;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // In IDLE the only bit that can be sampled is bit 0.
  assign pos = (state == IDLE) ? '0 : cnt + CW'(1);

  // --------------------------------------------------------------------------
  // Next-state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          sample  = 1'b1;
          state_n = (WIDTH == 1) ? DONE : RUN;
        end
      end
      RUN: begin
        sample = 1'b1;
        if (pos == LAST) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign last = sample && (pos == LAST);

  // --------------------------------------------------------------------------
  // Full-adder step. On the accepting edge the latched mode is not yet
  // loaded, so the live sub input supplies both the b inversion and the
  // initial carry (the +1 of two's complement).
  // --------------------------------------------------------------------------
  assign sub_eff = accept ? bus.sub : sub_l;
  assign b_eff   = bus.b ^ sub_eff;
  assign cin     = accept ? bus.sub : carry;
  assign fs      = bus.a ^ b_eff ^ cin;
  assign co      = (bus.a & b_eff) | (bus.a & cin) | (b_eff & cin);

  // Result bits enter at the MSB end so the last bit lands LSB-aligned.
  generate
    if (WIDTH == 1) begin : g_sum_one
      assign sum_n = fs;
    end else begin : g_sum_shift
      assign sum_n = {fs, sum_r[WIDTH-1:1]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      sub_l     <= 1'b0;
      carry     <= 1'b0;
      s_r       <= 1'b0;
      s_valid_r <= 1'b0;
      c_r       <= 1'b0;
      sum_r     <= '0;
    end else begin
      if (accept) begin
        sub_l <= bus.sub;
        c_r   <= 1'b0;
      end
      if (sample) begin
        cnt       <= pos;
        carry     <= co;
        s_r       <= fs;
        s_valid_r <= 1'b1;
        sum_r     <= sum_n;
        // For WIDTH=1 the accepting edge is also the last edge; the final
        // carry takes precedence over the clear above.
        if (last) begin
          c_r <= co;
        end
      end else begin
        s_valid_r <= 1'b0;
      end
    end
  end

  assign bus.s       = s_r;
  assign bus.s_valid = s_valid_r;
  assign bus.c       = c_r;
  assign bus.sum     = sum_r;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);

endmodule

`default_nettype wire
